// File: rtl/generador_listo_if.sv
// generador_listo_if: listo handshake bundle between the producer-side generator and its consumer
interface generador_listo_if;
  logic inicio;
  logic ack;
  logic listo;
  logic ocupado;
  logic perdido;
  modport master (input inicio, ack, output listo, ocupado, perdido);
  modport slave (output inicio, ack, input listo, ocupado, perdido);
endinterface

// File: rtl/generador_listo.sv
// generador_listo: turns a one-cycle inicio into a timed listo level (delay, hold window, forced low gap); GEN_LISTO_ACK_EN enables early release by ack
module generador_listo #(
  parameter int CW      = 8,
  parameter int DELAY   = 4,
  parameter int HOLD    = 8,
  parameter int GAP_MIN = 2
) (
  input logic               clk,
  input logic               reset,
  generador_listo_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, LISTO, GAP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          listo_q, ocupado_q, perdido_q;
  logic          rel_w;
`ifdef GEN_LISTO_ACK_EN
  assign rel_w = bus.ack;
`else
  logic unused_ack;
  assign unused_ack = bus.ack;
  assign rel_w = 1'b0;
`endif
  // Sequencer: counter reloads on each phase entry, all outputs registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      perdido_q <= bus.inicio && (state_q != IDLE);
      case (state_q)
        IDLE:
          if (bus.inicio) begin
            state_q   <= BUSY;
            cnt_q     <= CW'(DELAY - 1);
            ocupado_q <= 1'b1;
          end
        BUSY:
          if (cnt_q == '0) begin
            state_q <= LISTO;
            cnt_q   <= CW'(HOLD - 1);
            listo_q <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        LISTO:
          if (cnt_q == '0 || rel_w) begin
            state_q <= GAP;
            cnt_q   <= CW'(GAP_MIN - 1);
            listo_q <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        GAP:
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            ocupado_q <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.listo   = listo_q;
  assign bus.ocupado = ocupado_q;
  assign bus.perdido = perdido_q;
endmodule
